// File: rtl/bus_slave_burst.sv
// Serial-bus memory slave: decodes ID, address and burst length, then moves
// 1..2^BURST_LOG words between the serial line and a local memory port.
`timescale 1ns/1ps
module bus_slave_burst #(
  parameter int                  ADDRESS_WIDTH  = 15,
  parameter int                  DATA_WIDTH     = 8,
  parameter int                  ID_WIDTH       = 3,
  parameter logic [ID_WIDTH-1:0] SELF_ID        = {ID_WIDTH{1'b0}},
  parameter int                  BURST_LOG      = 2,
  parameter int                  TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rd_wrt,
  input  logic                     bus_util,
  input  logic                     arbiter_cmd_in,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_dv,
  output logic                     mem_wr_en,
  output logic                     mem_rd_req,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     busy_out,
  output logic                     timeout_err,
  output logic [3:0]               state_out,
  inout  wire                      data_bus_serial
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,  S_ID_RX    = 4'd1,  S_WAIT_PEER = 4'd2,  S_ADDR_RX = 4'd3,
    S_LEN_RX   = 4'd4,  S_ADDR_ACK = 4'd5,  S_WR_RX     = 4'd6,  S_WR_MEM  = 4'd7,
    S_WR_GRANT = 4'd8,  S_WR_ACK   = 4'd9,  S_RD_MEM    = 4'd10, S_RD_GRANT = 4'd11,
    S_RD_TX    = 4'd12
  } state_t;

  localparam int CW = $clog2(ADDRESS_WIDTH + DATA_WIDTH + ID_WIDTH + BURST_LOG + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_ID_LAST = CW'(ID_WIDTH - 1);
  localparam logic [CW-1:0] C_AD_LAST = CW'(ADDRESS_WIDTH - 1);
  localparam logic [CW-1:0] C_LN_LAST = CW'(BURST_LOG - 1);
  localparam logic [CW-1:0] C_DT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] C_DT_N    = CW'(DATA_WIDTH);
  localparam logic [TW-1:0] C_T_ZERO  = {TW{1'b0}};
  localparam logic [TW-1:0] C_T_ONE   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] C_T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t                   r_state, w_state;
  logic [CW-1:0]            r_cnt, w_cnt;
  logic [TW-1:0]            r_tmo, w_tmo;
  logic                     r_sub, w_sub, r_wr, w_wr;
  logic [ID_WIDTH-1:0]      r_id, w_id, w_id_sh;
  logic [BURST_LOG-1:0]     r_left, w_left, w_left_sh;
  logic [DATA_WIDTH-1:0]    r_rx, w_rx, w_rx_sh, r_tx, w_tx;
  logic [DATA_WIDTH-1:0]    r_mem_wdata, w_mem_wdata;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr, w_mem_addr, w_addr_sh;
  logic                     r_mem_wr_en, w_mem_wr_en, r_mem_rd_req, w_mem_rd_req;
  logic                     r_busy, w_busy, r_terr, w_terr;
  logic                     r_drv_en, w_drv_en, r_drv_val, w_drv_val;
  logic                     w_bus, w_wait;

  assign w_bus           = data_bus_serial;
  assign data_bus_serial = r_drv_en ? r_drv_val : 1'bz;

  // Serial fields arrive MSB first; the address shifts straight into mem_addr.
  assign w_id_sh   = ID_WIDTH'({r_id, w_bus});
  assign w_addr_sh = ADDRESS_WIDTH'({r_mem_addr, w_bus});
  assign w_left_sh = BURST_LOG'({r_left, w_bus});
  assign w_rx_sh   = DATA_WIDTH'({r_rx, w_bus});

  assign mem_wr_en   = r_mem_wr_en;
  assign mem_rd_req  = r_mem_rd_req;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign busy_out    = r_busy;
  assign timeout_err = r_terr;
  assign state_out   = r_state;

  // Next-state, datapath and output decode.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_tmo        = r_tmo;
    w_sub        = r_sub;
    w_wr         = r_wr;
    w_id         = r_id;
    w_left       = r_left;
    w_rx         = r_rx;
    w_tx         = r_tx;
    w_mem_wdata  = r_mem_wdata;
    w_mem_addr   = r_mem_addr;
    w_mem_wr_en  = 1'b0;
    w_mem_rd_req = 1'b0;
    w_busy       = r_busy;
    w_terr       = 1'b0;
    w_drv_en     = r_drv_en;
    w_drv_val    = r_drv_val;
    w_wait       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt = C_ZERO;
        w_sub = 1'b0;
        if (!w_bus) w_state = S_ID_RX;
        else        w_state = S_IDLE;
      end
      S_ID_RX: begin
        w_id = w_id_sh;
        if (r_cnt == C_ID_LAST) begin
          w_cnt   = C_ZERO;
          w_state = (w_id_sh == SELF_ID) ? S_ADDR_RX : S_WAIT_PEER;
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      S_WAIT_PEER: begin
        if (bus_util) w_state = S_IDLE;
        else          w_state = S_WAIT_PEER;
      end
      S_ADDR_RX: begin
        w_mem_addr = w_addr_sh;
        if (r_cnt == C_AD_LAST) begin
          w_cnt   = C_ZERO;
          w_state = S_LEN_RX;
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      S_LEN_RX: begin
        w_left = w_left_sh;
        if (r_cnt == C_LN_LAST) begin
          w_cnt     = C_ZERO;
          w_drv_en  = 1'b1;
          w_drv_val = 1'b0;
          w_state   = S_ADDR_ACK;
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      S_ADDR_ACK: begin
        if (r_cnt == C_ZERO) begin
          w_wr  = rd_wrt;
          w_cnt = C_ONE;
        end else begin
          w_cnt    = C_ZERO;
          w_drv_en = 1'b0;
          w_sub    = 1'b0;
          if (r_wr) begin
            w_state = S_WR_RX;
          end else begin
            w_mem_rd_req = 1'b1;
            w_busy       = 1'b1;
            w_state      = S_RD_MEM;
          end
        end
      end
      S_WR_RX: begin
        if (!r_sub) begin
          if (!w_bus) begin
            w_sub = 1'b1;
            w_cnt = C_ZERO;
          end else begin
            w_wait = 1'b1;
          end
        end else begin
          w_rx = w_rx_sh;
          if (r_cnt == C_DT_LAST) begin
            w_sub       = 1'b0;
            w_cnt       = C_ZERO;
            w_mem_wdata = w_rx_sh;
            w_mem_wr_en = 1'b1;
            w_busy      = 1'b1;
            w_state     = S_WR_MEM;
          end else begin
            w_cnt = r_cnt + C_ONE;
          end
        end
      end
      S_WR_MEM: begin
        if (mem_dv) begin
          w_busy = 1'b0;
          if (r_left == {BURST_LOG{1'b0}}) begin
            w_state = S_WR_GRANT;
          end else begin
            w_left     = r_left - {{(BURST_LOG-1){1'b0}}, 1'b1};
            w_mem_addr = r_mem_addr + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
            w_state    = S_WR_RX;
          end
        end else begin
          w_wait = 1'b1;
        end
      end
      S_WR_GRANT: begin
        if (arbiter_cmd_in) begin
          w_drv_en  = 1'b1;
          w_drv_val = 1'b0;
          w_cnt     = C_ZERO;
          w_state   = S_WR_ACK;
        end else begin
          w_wait = 1'b1;
        end
      end
      S_WR_ACK: begin
        if (r_cnt == C_ZERO) begin
          w_drv_val = 1'b1;
          w_cnt     = C_ONE;
        end else begin
          w_drv_en = 1'b0;
          w_cnt    = C_ZERO;
          w_state  = S_IDLE;
        end
      end
      S_RD_MEM: begin
        if (mem_dv) begin
          w_tx    = mem_rdata;
          w_busy  = 1'b0;
          w_state = S_RD_GRANT;
        end else begin
          w_wait = 1'b1;
        end
      end
      S_RD_GRANT: begin
        if (arbiter_cmd_in) begin
          w_drv_en  = 1'b1;
          w_drv_val = 1'b0;
          w_cnt     = C_ZERO;
          w_state   = S_RD_TX;
        end else begin
          w_wait = 1'b1;
        end
      end
      S_RD_TX: begin
        // r_cnt counts frame bits already placed after the start bit.
        if (r_cnt < C_DT_N) begin
          w_drv_val = r_tx[DATA_WIDTH-1];
          w_tx      = DATA_WIDTH'({r_tx, 1'b0});
          w_cnt     = r_cnt + C_ONE;
        end else if (r_cnt == C_DT_N) begin
          w_drv_val = 1'b1;
          w_cnt     = r_cnt + C_ONE;
        end else begin
          w_drv_en = 1'b0;
          w_cnt    = C_ZERO;
          if (r_left == {BURST_LOG{1'b0}}) begin
            w_state = S_IDLE;
          end else begin
            w_left       = r_left - {{(BURST_LOG-1){1'b0}}, 1'b1};
            w_mem_addr   = r_mem_addr + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
            w_mem_rd_req = 1'b1;
            w_busy       = 1'b1;
            w_state      = S_RD_MEM;
          end
        end
      end
      default: begin
        w_drv_en = 1'b0;
        w_busy   = 1'b0;
        w_state  = S_IDLE;
      end
    endcase
    // Any cycle spent waiting counts toward the abort; leaving a wait clears it.
    if (w_wait && (r_tmo == C_T_LAST)) begin
      w_tmo    = C_T_ZERO;
      w_terr   = 1'b1;
      w_busy   = 1'b0;
      w_drv_en = 1'b0;
      w_sub    = 1'b0;
      w_state  = S_IDLE;
    end else if (w_wait) begin
      w_tmo = r_tmo + C_T_ONE;
    end else begin
      w_tmo = C_T_ZERO;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= C_ZERO;
      r_tmo        <= C_T_ZERO;
      r_sub        <= 1'b0;
      r_wr         <= 1'b0;
      r_id         <= {ID_WIDTH{1'b0}};
      r_left       <= {BURST_LOG{1'b0}};
      r_rx         <= {DATA_WIDTH{1'b0}};
      r_tx         <= {DATA_WIDTH{1'b0}};
      r_mem_wdata  <= {DATA_WIDTH{1'b0}};
      r_mem_addr   <= {ADDRESS_WIDTH{1'b0}};
      r_mem_wr_en  <= 1'b0;
      r_mem_rd_req <= 1'b0;
      r_busy       <= 1'b0;
      r_terr       <= 1'b0;
      r_drv_en     <= 1'b0;
      r_drv_val    <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_tmo        <= w_tmo;
      r_sub        <= w_sub;
      r_wr         <= w_wr;
      r_id         <= w_id;
      r_left       <= w_left;
      r_rx         <= w_rx;
      r_tx         <= w_tx;
      r_mem_wdata  <= w_mem_wdata;
      r_mem_addr   <= w_mem_addr;
      r_mem_wr_en  <= w_mem_wr_en;
      r_mem_rd_req <= w_mem_rd_req;
      r_busy       <= w_busy;
      r_terr       <= w_terr;
      r_drv_en     <= w_drv_en;
      r_drv_val    <= w_drv_val;
    end
  end

endmodule

// File: doc/bus_slave_burst.md
# bus_slave_burst

Parameterised serial-bus slave that decodes a configurable-width slave ID, receives an address and a burst length, and moves 1..2^BURST_LOG consecutive data words between the shared single-wire serial bus and a local memory port. It replaces the fixed 3-bit-ID single-word slave behind each memory node. It adds burst transfers, address auto-increment with wrap-around, and timeouts on every wait state.

## Interface
- ADDRESS_WIDTH, 15, memory word-address width
- DATA_WIDTH, 8, data word width
- ID_WIDTH, 3, slave ID width
- SELF_ID, 0, this slave's ID (ID_WIDTH bits)
- BURST_LOG, 2, width of the serial burst-length field; maximum burst is 2^BURST_LOG words
- TIMEOUT_CYCLES, 16, maximum cycles allowed in any wait state (≥2)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- rd_wrt  in  1  transfer direction from master: 1 = write, 0 = read; sampled in first ADDR_ACK cycle
- bus_util  in  1  high marks the end of a transaction on the bus
- arbiter_cmd_in  in  1  grant: slave may drive the bus next cycle
- mem_rdata  in  DATA_WIDTH  read data from memory
- mem_dv  in  1  memory completion strobe (write done / read data valid)
- mem_wr_en  out  1  one-cycle write strobe
- mem_rd_req  out  1  one-cycle read request
- mem_addr  out  ADDRESS_WIDTH  current word address
- mem_wdata  out  DATA_WIDTH  write data
- busy_out  out  1  high while a memory access is outstanding
- timeout_err  out  1  one-cycle pulse on timeout abort
- state_out  out  4  current FSM state
- data_bus_serial  inout  1  shared serial line; idle high (pulled up); released (Z) unless driving

## Operation
- Serial fields are MSB first, one bit per clk, and are sampled on the rising edge.
- States and transitions:
  - IDLE(0): bus == 0 (start bit) -> ID_RX.
  - ID_RX(1): shift ID_WIDTH bits. On match -> ADDR_RX; on mismatch -> WAIT_PEER.
  - WAIT_PEER(2): bus_util == 1 -> IDLE.
  - ADDR_RX(3): shift ADDRESS_WIDTH bits into base address -> LEN_RX.
  - LEN_RX(4): shift BURST_LOG bits into L; burst length N = L + 1 -> ADDR_ACK.
  - ADDR_ACK(5): drive 0 for 2 cycles; latch rd_wrt in cycle 1. Write -> WR_RX; read -> RD_MEM.
  - WR_RX(6): bus released. Wait for start bit 0, then shift DATA_WIDTH bits -> WR_MEM.
  - WR_MEM(7): mem_wr_en pulses 1 cycle with mem_addr and mem_wdata valid; busy_out = 1 until mem_dv. If words remain -> WR_RX; otherwise -> WR_GRANT.
  - WR_GRANT(8): arbiter_cmd_in -> WR_ACK.
  - WR_ACK(9): drive 0 for 1 cycle, then 1 for 1 cycle, then release -> IDLE.
  - RD_MEM(10): mem_rd_req pulses 1 cycle; busy_out = 1; on mem_dv latch mem_rdata -> RD_GRANT.
  - RD_GRANT(11): arbiter_cmd_in -> RD_TX.
  - RD_TX(12): drive start 0, then DATA_WIDTH bits, then stop 1, then release. If words remain -> RD_MEM; otherwise -> IDLE.
- Address: mem_addr = (base + index) mod 2^ADDRESS_WIDTH, index 0..N-1. 0x7FFF + 1 wraps to 0x0000.
- Timeout: a counter clears on entry to WR_RX (start wait), WR_MEM, WR_GRANT, RD_MEM and RD_GRANT, and increments each cycle in those states. On reaching TIMEOUT_CYCLES: timeout_err pulses, bus is released, busy_out = 0, -> IDLE; the remaining burst is dropped.
- mem_dv arriving in the same cycle as the strobe is accepted (zero-wait memory).
- mem_dv outside WR_MEM/RD_MEM is ignored. arbiter_cmd_in outside the grant states is ignored.

## Timing
- All outputs are registered. Reset values: mem_wr_en = 0, mem_rd_req = 0, mem_addr = 0, mem_wdata = 0, busy_out = 0, timeout_err = 0, state_out = 0, bus = Z.
- Asynchronous reset mid-transfer: the bus is released immediately; state -> IDLE; no pending strobe fires.
- Header cycle numbering: start bit sampled at cycle 0; ID at cycles 1..ID_WIDTH; address and length follow contiguously. The slave drives ack 0 starting on the edge after the last length bit is sampled.
- Write data word: mem_wr_en asserts on the edge after the last data bit is sampled.
- Read: the start bit appears on the bus on the edge after arbiter_cmd_in is sampled high. One frame occupies DATA_WIDTH+2 cycles.
- Grant is requested per read word, and once after the full write burst.

## Test plan
- Write, N=1: SELF_ID=3'b101; send ID 101, addr 0x0123, L=00, rd_wrt=1, data 0xA5 -> 2-cycle ack 0; mem_wr_en with addr 0x0123, wdata 0xA5; after mem_dv and grant, bus shows 0 then 1 -> IDLE.
- Read burst: addr 0x7FFE, L=11, mem_rdata = addr[7:0], mem_dv 2 cycles after each request -> mem_addr sequence 7FFE, 7FFF, 0000, 0001; frames carry 0xFE, 0xFF, 0x00, 0x01, each start 0 / stop 1.
- ID mismatch: send ID 011 -> no bus drive and no strobes; state_out = 2 until bus_util = 1, then 0.
- Timeout: write header only, no data start bit -> after TIMEOUT_CYCLES, timeout_err pulses once, state_out = 0, bus = Z.
- Memory stall: mem_dv never asserts on a read -> busy_out = 1 until timeout, then busy_out = 0 and timeout_err pulses.
- Reset mid-RD_TX: rstn = 0 during data bit 3 -> bus = Z and all outputs at reset values in the same cycle; the next start bit is decoded normally.
